// File: rtl/va_ovc_state_pkg.sv
// Shared definitions for the output-VC state tracker.
//   ovc_state_e : per-VC ownership state (IDLE / ACTIVE / DRAIN)
//   V_DEF, BUF_DEPTH_DEF : default virtual-channel count and downstream buffer depth
package va_ovc_state_pkg;

    localparam int V_DEF         = 4;
    localparam int BUF_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        OVC_IDLE   = 2'd0,
        OVC_ACTIVE = 2'd1,
        OVC_DRAIN  = 2'd2
    } ovc_state_e;

endpackage

// File: rtl/va_ovc_state_credit_fsm.sv
// ovc_credit_fsm: ownership FSM and downstream credit counter for one output VC.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   grant           : VA grant for this VC
//   send, tail      : a flit (tail flag) leaves on this VC; already one-hot qualified
//   credit          : downstream returned a credit for this VC; already qualified
//   available       : VC is IDLE and may be allocated
//   has_credit      : credit count is non-zero
//   count           : current credit count
//   err             : single-cycle protocol-violation pulse
module ovc_credit_fsm
    import va_ovc_state_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          grant,
    input  logic          send,
    input  logic          tail,
    input  logic          credit,
    output logic          available,
    output logic          has_credit,
    output logic [CW-1:0] count,
    output logic          err
);

    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    ovc_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          only_send, only_credit;

    // A send and a credit on the same VC cancel out, so neither the
    // underflow nor the overflow check applies to that pair.
    assign only_send   = send && !credit;
    assign only_credit = credit && !send;

    always_comb begin
        cnt_nxt = cnt;
        if (only_send && cnt != '0)
            cnt_nxt = cnt - 1'b1;
        else if (only_credit && cnt != FULL)
            cnt_nxt = cnt + 1'b1;

        state_nxt = state;
        case (state)
            OVC_IDLE:   if (grant)        state_nxt = OVC_ACTIVE;
            OVC_ACTIVE: if (send && tail) state_nxt = OVC_DRAIN;
            default:    ;
        endcase
        // Drain completes on the credit that refills the buffer; this also
        // covers a tail and a credit arriving together.
        if (state_nxt == OVC_DRAIN && credit && cnt_nxt == FULL)
            state_nxt = OVC_IDLE;

        err = (only_send && cnt == '0)
            || (only_credit && cnt == FULL)
            || (grant && state != OVC_IDLE)
            || (send && state != OVC_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OVC_IDLE;
            cnt   <= FULL;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign available  = (state == OVC_IDLE);
    assign has_credit = (cnt != '0);
    assign count      = cnt;

endmodule

// File: rtl/va_ovc_state.sv
// va_ovc_state: per-output-port tracker of output-VC ownership and credits.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   vaGrant[V]                       : VCs granted by the VC allocator this cycle
//   flitSentValid/flitSentVC/Tail    : flit leaving the port, one-hot VC, tail flag
//   creditValid/creditVC             : credit returned by downstream, one-hot VC
//   outVCAvailable[V]                : VC is IDLE
//   hasCredit[V]                     : VC credit count non-zero
//   creditCount[V*CW]                : VC j count at [j*CW +: CW]
//   protoErr                         : sticky protocol-violation flag
module va_ovc_state
    import va_ovc_state_pkg::*;
#(
    parameter int V         = V_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [V-1:0]    vaGrant,
    input  logic            flitSentValid,
    input  logic [V-1:0]    flitSentVC,
    input  logic            flitSentTail,
    input  logic            creditValid,
    input  logic [V-1:0]    creditVC,
    output logic [V-1:0]    outVCAvailable,
    output logic [V-1:0]    hasCredit,
    output logic [V*CW-1:0] creditCount,
    output logic            protoErr
);

    logic         send_ok, credit_ok, sel_err;
    logic [V-1:0] vc_err;

    // A malformed VC select drops that event entirely.
    assign send_ok   = flitSentValid && $onehot(flitSentVC);
    assign credit_ok = creditValid && $onehot(creditVC);
    assign sel_err   = (flitSentValid && !$onehot(flitSentVC))
                     || (creditValid && !$onehot(creditVC));

    for (genvar j = 0; j < V; j++) begin : g_vc
        ovc_credit_fsm #(
            .BUF_DEPTH (BUF_DEPTH),
            .CW        (CW)
        ) u_vc (
            .clk        (clk),
            .rst        (rst),
            .grant      (vaGrant[j]),
            .send       (send_ok && flitSentVC[j]),
            .tail       (flitSentTail),
            .credit     (credit_ok && creditVC[j]),
            .available  (outVCAvailable[j]),
            .has_credit (hasCredit[j]),
            .count      (creditCount[j*CW +: CW]),
            .err        (vc_err[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) protoErr <= 1'b0;
        else     protoErr <= protoErr || sel_err || (|vc_err);
    end

endmodule

// File: tb/tb_va_ovc_state.sv
module tb_va_ovc_state;

    localparam int V  = 4;
    localparam int BD = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [V-1:0]    vaGrant = '0;
    logic            flitSentValid = 1'b0;
    logic [V-1:0]    flitSentVC = '0;
    logic            flitSentTail = 1'b0;
    logic            creditValid = 1'b0;
    logic [V-1:0]    creditVC = '0;
    logic [V-1:0]    outVCAvailable;
    logic [V-1:0]    hasCredit;
    logic [V*CW-1:0] creditCount;
    logic            protoErr;

    va_ovc_state #(.V(V), .BUF_DEPTH(BD)) dut (
        .clk(clk), .rst(rst), .vaGrant(vaGrant),
        .flitSentValid(flitSentValid), .flitSentVC(flitSentVC), .flitSentTail(flitSentTail),
        .creditValid(creditValid), .creditVC(creditVC),
        .outVCAvailable(outVCAvailable), .hasCredit(hasCredit),
        .creditCount(creditCount), .protoErr(protoErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ownership (0 free, 1 owned, 2 draining), credits, error flag
    int owner [V];
    int credits [V];
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < V; j++) begin
            owner[j]   = 0;
            credits[j] = BD;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic [V-1:0] g, input logic sv, input logic [V-1:0] svc,
                              input logic tl, input logic cv, input logic [V-1:0] cvc);
        bit s_ok, c_ok, s, c;
        int nm;
        s_ok = sv && ($countones(svc) == 1);
        c_ok = cv && ($countones(cvc) == 1);
        if ((sv && !s_ok) || (cv && !c_ok)) m_err = 1'b1;
        for (int j = 0; j < V; j++) begin
            s  = s_ok && svc[j];
            c  = c_ok && cvc[j];
            nm = owner[j];
            if (g[j]) begin
                if (owner[j] == 0) nm = 1; else m_err = 1'b1;
            end
            if (s) begin
                if (owner[j] != 1) m_err = 1'b1;
                else if (tl) nm = 2;
            end
            if (s && !c) begin
                if (credits[j] == 0) m_err = 1'b1; else credits[j]--;
            end
            if (c && !s) begin
                if (credits[j] == BD) m_err = 1'b1; else credits[j]++;
            end
            if (c && nm == 2 && credits[j] == BD) nm = 0;
            owner[j] = nm;
        end
    endtask

    task automatic check_model();
        logic [V-1:0]    ea, eh;
        logic [V*CW-1:0] ec;
        for (int j = 0; j < V; j++) begin
            ea[j]           = (owner[j] == 0);
            eh[j]           = (credits[j] != 0);
            ec[j*CW +: CW]  = CW'(credits[j]);
        end
        chk("model_avail", 32'(outVCAvailable), 32'(ea));
        chk("model_hascredit", 32'(hasCredit), 32'(eh));
        chk("model_count", 32'(creditCount), 32'(ec));
        chk("model_err", 32'(protoErr), 32'(m_err));
    endtask

    task automatic drive(input logic [V-1:0] g, input logic sv, input logic [V-1:0] svc,
                         input logic tl, input logic cv, input logic [V-1:0] cvc);
        vaGrant = g; flitSentValid = sv; flitSentVC = svc; flitSentTail = tl;
        creditValid = cv; creditVC = cvc;
        model_step(g, sv, svc, tl, cv, cvc);
        @(posedge clk); #1;
        vaGrant = '0; flitSentValid = 1'b0; flitSentVC = '0; flitSentTail = 1'b0;
        creditValid = 1'b0; creditVC = '0;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_model();
    endtask

    function automatic int cnt_of(input int j);
        logic [V*CW-1:0] cc;
        cc = creditCount;
        return int'(cc[j*CW +: CW]);
    endfunction

    initial begin
        logic [V-1:0] g, svc, cvc;
        model_reset();

        // 1: reset and idle
        do_reset();
        repeat (3) drive('0, 0, '0, 0, 0, '0);
        chk("rst_avail", 32'(outVCAvailable), 32'hF);
        chk("rst_hascredit", 32'(hasCredit), 32'hF);
        chk("rst_count", 32'(creditCount), 32'h924); // 4 in every 3-bit field
        chk("rst_err", 32'(protoErr), 32'h0);

        // 2: grant VC1, overrun the downstream buffer
        drive(4'b0010, 0, '0, 0, 0, '0);
        chk("grant_avail", 32'(outVCAvailable), 32'hD);
        repeat (4) drive('0, 1, 4'b0010, 0, 0, '0);
        chk("vc1_empty_count", 32'(cnt_of(1)), 32'd0);
        chk("vc1_empty_hascredit", 32'(hasCredit), 32'hD);
        chk("vc1_empty_noerr", 32'(protoErr), 32'h0);
        drive('0, 1, 4'b0010, 1, 0, '0);
        chk("underflow_err", 32'(protoErr), 32'h1);
        chk("underflow_count", 32'(cnt_of(1)), 32'd0);

        // 2b: legal 3 body + tail
        do_reset();
        drive(4'b0010, 0, '0, 0, 0, '0);
        repeat (3) drive('0, 1, 4'b0010, 0, 0, '0);
        drive('0, 1, 4'b0010, 1, 0, '0);
        chk("tail_count", 32'(cnt_of(1)), 32'd0);
        chk("tail_noerr", 32'(protoErr), 32'h0);

        // 3: drain back to idle
        for (int k = 0; k < 3; k++) begin
            drive('0, 0, '0, 0, 1, 4'b0010);
            chk("drain_busy", 32'(outVCAvailable[1]), 32'h0);
        end
        drive('0, 0, '0, 0, 1, 4'b0010);
        chk("drain_done_avail", 32'(outVCAvailable), 32'hF);
        chk("drain_done_count", 32'(cnt_of(1)), 32'd4);

        // 4: tail and credit together on VC2
        drive(4'b0100, 0, '0, 0, 0, '0);
        repeat (2) drive('0, 1, 4'b0100, 0, 0, '0);
        drive('0, 1, 4'b0100, 1, 1, 4'b0100);
        chk("pair_count", 32'(cnt_of(2)), 32'd2);
        chk("pair_busy", 32'(outVCAvailable[2]), 32'h0);
        chk("pair_noerr", 32'(protoErr), 32'h0);
        drive('0, 0, '0, 0, 1, 4'b0100);
        chk("pair_drain_busy", 32'(outVCAvailable[2]), 32'h0);
        drive('0, 0, '0, 0, 1, 4'b0100);
        chk("pair_drain_idle", 32'(outVCAvailable[2]), 32'h1);

        // 5: regrant, overflow, mid-packet reset
        drive(4'b0001, 0, '0, 0, 0, '0);
        drive(4'b0001, 0, '0, 0, 0, '0);
        chk("regrant_err", 32'(protoErr), 32'h1);
        chk("regrant_busy", 32'(outVCAvailable[0]), 32'h0);
        drive('0, 0, '0, 0, 1, 4'b1000);
        chk("overflow_count", 32'(cnt_of(3)), 32'd4);
        chk("overflow_err", 32'(protoErr), 32'h1);
        drive('0, 1, 4'b0001, 0, 0, '0);
        do_reset();
        chk("midrst_avail", 32'(outVCAvailable), 32'hF);
        chk("midrst_count", 32'(creditCount), 32'h924);
        chk("midrst_err", 32'(protoErr), 32'h0);

        // 6: multi-grant, malformed send select
        drive(4'b1001, 0, '0, 0, 0, '0);
        chk("multigrant_avail", 32'(outVCAvailable), 32'h6);
        drive('0, 1, 4'b0011, 0, 0, '0);
        chk("badsel_count", 32'(creditCount), 32'h924);
        chk("badsel_err", 32'(protoErr), 32'h1);

        // Randomised traffic against the reference model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                g   = ($urandom_range(0, 3) == 0) ? V'($urandom) : '0;
                svc = ($urandom_range(0, 15) == 0) ? V'($urandom) : V'(1 << $urandom_range(0, V-1));
                cvc = ($urandom_range(0, 15) == 0) ? V'($urandom) : V'(1 << $urandom_range(0, V-1));
                drive(g, 1'($urandom_range(0, 1)), svc, ($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 1)), cvc);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
